// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the motor PWM core.
//   - motor_state_e : bridge FSM state encoding (matches state_o)
//   - CTRL_*_BIT    : bit positions in the control register
//   - DEFAULT_CNT_W : default width of the period/duty counters
package motor_pkg;

  localparam int DEFAULT_CNT_W   = 16;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_BRAKE_BIT  = 1;
  localparam int CTRL_DIR_BIT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_BRAKE = 2'd3
  } motor_state_e;

endpackage

// File: rtl/pwm_shadow_regs.sv
// pwm_shadow_regs: staging and active copies of direction/period/duty.
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_update          : strobe capturing cfg_dir/period/duty into staging
//   cfg_dir/period/duty : values to stage
//   apply               : the FSM is at an apply point this edge
//   act_*_reg           : values currently driving the PWM
//   act_*_next          : values the active registers take at this edge
//   update_pending      : staging holds values not yet applied
module pwm_shadow_regs
  import motor_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_update,
  input  logic             cfg_dir,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic             apply,
  output logic             act_dir_reg,
  output logic [CNT_W-1:0] act_period_reg,
  output logic [CNT_W-1:0] act_duty_reg,
  output logic             act_dir_next,
  output logic [CNT_W-1:0] act_period_next,
  output logic [CNT_W-1:0] act_duty_next,
  output logic             update_pending
);

  logic             stg_dir_reg;
  logic [CNT_W-1:0] stg_period_reg;
  logic [CNT_W-1:0] stg_duty_reg;
  logic             pending_reg;
  logic             pending_next;
  logic             do_apply;

  // Only a pending staging set is ever copied; an apply point with nothing
  // staged leaves the active values untouched.
  assign do_apply        = apply && pending_reg;
  assign act_dir_next    = do_apply ? stg_dir_reg    : act_dir_reg;
  assign act_period_next = do_apply ? stg_period_reg : act_period_reg;
  assign act_duty_next   = do_apply ? stg_duty_reg   : act_duty_reg;

  // A strobe landing on the apply edge refills staging, so it must stay
  // pending for the following apply point.
  assign pending_next    = cfg_update ? 1'b1 : (do_apply ? 1'b0 : pending_reg);
  assign update_pending  = pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_dir_reg    <= 1'b0;
      stg_period_reg <= '0;
      stg_duty_reg   <= '0;
      act_dir_reg    <= 1'b0;
      act_period_reg <= '0;
      act_duty_reg   <= '0;
      pending_reg    <= 1'b0;
    end else begin
      if (cfg_update) begin
        stg_dir_reg    <= cfg_dir;
        stg_period_reg <= cfg_period;
        stg_duty_reg   <= cfg_duty;
      end
      act_dir_reg    <= act_dir_next;
      act_period_reg <= act_period_next;
      act_duty_reg   <= act_duty_next;
      pending_reg    <= pending_next;
    end
  end

endmodule

// File: rtl/motor_pwm_core.sv
// motor_pwm_core: shadow-buffered PWM generator for one H-bridge with dead
// time on direction reversal and live brake/enable override.
//   ACLK, ARESET        : clock, asynchronous active-high reset
//   ctrl_enable/brake   : live control bits
//   cfg_dir/period/duty : staged configuration, captured on cfg_update
//   pwm_a, pwm_b        : bridge legs (A drives forward, B reverse)
//   period_tick         : pulse during the last counter cycle of a RUN period
//   update_pending      : staged values not yet applied
//   state_o             : FSM state (0 IDLE, 1 RUN, 2 DEAD, 3 BRAKE)
module motor_pwm_core
  import motor_pkg::*;
#(
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int DEADTIME_CYCLES = 50
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             ctrl_enable,
  input  logic             ctrl_brake,
  input  logic             cfg_dir,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic             cfg_update,
  output logic             pwm_a,
  output logic             pwm_b,
  output logic             period_tick,
  output logic             update_pending,
  output logic [1:0]       state_o
);

  localparam int DEAD_W = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME_CYCLES);

  motor_state_e      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DEAD_W-1:0] dead_reg, dead_next;
  logic              last_dir_reg, last_dir_next;
  logic              pwm_a_reg, pwm_a_next;
  logic              pwm_b_reg, pwm_b_next;
  logic              tick_reg, tick_next;

  logic              apply;
  logic              wrap;
  logic              run_active;
  logic              leg_on;
  logic [CNT_W-1:0]  period_m1;

  logic              act_dir_reg, act_dir_next;
  logic [CNT_W-1:0]  act_period_reg, act_period_next;
  logic [CNT_W-1:0]  act_duty_reg, act_duty_next;

  pwm_shadow_regs #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk             (ACLK),
    .rst             (ARESET),
    .cfg_update      (cfg_update),
    .cfg_dir         (cfg_dir),
    .cfg_period      (cfg_period),
    .cfg_duty        (cfg_duty),
    .apply           (apply),
    .act_dir_reg     (act_dir_reg),
    .act_period_reg  (act_period_reg),
    .act_duty_reg    (act_duty_reg),
    .act_dir_next    (act_dir_next),
    .act_period_next (act_period_next),
    .act_duty_next   (act_duty_next),
    .update_pending  (update_pending)
  );

  // A degenerate period (<2) counts as wrapping every cycle so that a staged
  // update can still be applied and bring the bridge out of that state.
  assign period_m1 = act_period_reg - CNT_W'(1);
  assign wrap      = (act_period_reg < CNT_W'(2)) || (cnt_reg == period_m1);

  // Kept out of the next-state block: it must not depend on act_*_next.
  assign apply = (state_reg == ST_IDLE) ||
                 ((state_reg == ST_RUN) && !ctrl_brake && ctrl_enable && wrap);

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      dead_reg     <= '0;
      last_dir_reg <= 1'b0;
      pwm_a_reg    <= 1'b0;
      pwm_b_reg    <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dead_reg     <= dead_next;
      last_dir_reg <= last_dir_next;
      pwm_a_reg    <= pwm_a_next;
      pwm_b_reg    <= pwm_b_next;
      tick_reg     <= tick_next;
    end
  end

  // Next-state logic: brake beats disable beats normal sequencing.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dead_next  = dead_reg;
    if (ctrl_brake) begin
      state_next = ST_BRAKE;
      cnt_next   = '0;
      dead_next  = '0;
    end else if (!ctrl_enable || (state_reg == ST_BRAKE)) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      dead_next  = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next = '0;
          if (act_dir_next != last_dir_reg) begin
            state_next = ST_DEAD;
            dead_next  = DEAD_LOAD;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            cnt_next = '0;
            if (act_dir_next != act_dir_reg) begin
              state_next = ST_DEAD;
              dead_next  = DEAD_LOAD;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          // Loaded with DEADTIME_CYCLES on entry, so leaving while the
          // counter reads 1 gives exactly DEADTIME_CYCLES low cycles.
          if (dead_reg <= DEAD_W'(1)) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            dead_next  = '0;
          end else begin
            dead_next = dead_reg - DEAD_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          dead_next  = '0;
        end
      endcase
    end
  end

  // Output logic, evaluated on the next-state values so the registered
  // outputs line up with the registered counter. The driven direction is
  // committed as soon as the dead interval for it starts, so a brake that
  // interrupts DEAD does not force a second dead interval for the same dir.
  always_comb begin
    run_active    = (state_next == ST_RUN) && (act_period_next >= CNT_W'(2));
    leg_on        = run_active && (cnt_next < act_duty_next);
    pwm_a_next    = (state_next == ST_BRAKE) || (leg_on && !act_dir_next);
    pwm_b_next    = (state_next == ST_BRAKE) || (leg_on && act_dir_next);
    tick_next     = run_active && (cnt_next == (act_period_next - CNT_W'(1)));
    last_dir_next = ((state_next == ST_RUN) || (state_next == ST_DEAD)) ?
                    act_dir_next : last_dir_reg;
  end

  assign pwm_a       = pwm_a_reg;
  assign pwm_b       = pwm_b_reg;
  assign period_tick = tick_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_motor_pwm_core.sv
// tb_motor_pwm_core: directed bench for motor_pwm_core (CNT_W=16,
// DEADTIME_CYCLES=50). Inputs change on the falling edge; outputs are
// sampled on the falling edge after the rising edge that produced them.
module tb_motor_pwm_core;

  logic        tb_ACLK;
  logic        ARESET;
  logic        ctrl_enable;
  logic        ctrl_brake;
  logic        cfg_dir;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic        cfg_update;
  logic        pwm_a;
  logic        pwm_b;
  logic        period_tick;
  logic        update_pending;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  motor_pwm_core #(
    .CNT_W           (16),
    .DEADTIME_CYCLES (50)
  ) dut (
    .ACLK           (tb_ACLK),
    .ARESET         (ARESET),
    .ctrl_enable    (ctrl_enable),
    .ctrl_brake     (ctrl_brake),
    .cfg_dir        (cfg_dir),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .cfg_update     (cfg_update),
    .pwm_a          (pwm_a),
    .pwm_b          (pwm_b),
    .period_tick    (period_tick),
    .update_pending (update_pending),
    .state_o        (state_o)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge tb_ACLK);
  endtask

  initial begin
    ARESET      = 1'b1;
    ctrl_enable = 1'b0;
    ctrl_brake  = 1'b0;
    cfg_dir     = 1'b0;
    cfg_period  = 16'd0;
    cfg_duty    = 16'd0;
    cfg_update  = 1'b0;
    cyc(3);

    // Reset state
    chk1("rst_pwm_a", pwm_a, 1'b0);
    chk1("rst_pwm_b", pwm_b, 1'b0);
    chk1("rst_tick", period_tick, 1'b0);
    chk1("rst_pending", update_pending, 1'b0);
    chk2("rst_state", state_o, 2'd0);
    ARESET = 1'b0;
    cyc(2);
    chk2("idle_after_rst", state_o, 2'd0);

    // Period 10, duty 3, forward: staged, applied in IDLE, then RUN
    cfg_period = 16'd10; cfg_duty = 16'd3; cfg_dir = 1'b0; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    chk1("p1_pend_set", update_pending, 1'b1);
    chk2("p1_still_idle", state_o, 2'd0);
    cyc(1);
    chk1("p1_pend_clr", update_pending, 1'b0);
    ctrl_enable = 1'b1;
    cyc(1);
    chk2("p1_run", state_o, 2'd1);
    for (int k = 0; k < 20; k++) begin
      chk1("p1_pwm_a", pwm_a, (k % 10) < 3);
      chk1("p1_pwm_b", pwm_b, 1'b0);
      chk1("p1_tick", period_tick, (k % 10) == 9);
      cyc(1);
    end

    // Duty 7 staged mid-period: old duty holds until the wrap
    cyc(4);
    cfg_duty = 16'd7; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    for (int k = 5; k < 10; k++) begin
      chk1("p2_pend_hold", update_pending, 1'b1);
      chk1("p2_old_duty", pwm_a, 1'b0);
      cyc(1);
    end
    for (int k = 0; k < 10; k++) begin
      chk1("p2_new_duty", pwm_a, k < 7);
      if (k == 0) chk1("p2_pend_clr", update_pending, 1'b0);
      cyc(1);
    end

    // Reversal to dir=1, duty 3: 50 dead cycles at the wrap, then leg B
    cfg_dir = 1'b1; cfg_duty = 16'd3; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    chk1("p3_old_dir_a", pwm_a, 1'b1);
    cyc(9);
    for (int k = 0; k < 50; k++) begin
      chk2("p3_dead_state", state_o, 2'd2);
      chk1("p3_dead_a", pwm_a, 1'b0);
      chk1("p3_dead_b", pwm_b, 1'b0);
      cyc(1);
    end
    chk2("p3_run_again", state_o, 2'd1);
    for (int k = 0; k < 10; k++) begin
      chk1("p3_rev_b", pwm_b, k < 3);
      chk1("p3_rev_a", pwm_a, 1'b0);
      cyc(1);
    end

    // Reverse back to dir=0, brake during DEAD, release, re-enable
    cfg_dir = 1'b0; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    cyc(9);
    cyc(5);
    chk2("p4_in_dead", state_o, 2'd2);
    ctrl_brake = 1'b1;
    cyc(1);
    chk2("p4_brake_state", state_o, 2'd3);
    chk1("p4_brake_a", pwm_a, 1'b1);
    chk1("p4_brake_b", pwm_b, 1'b1);
    cyc(2);
    chk2("p4_brake_hold", state_o, 2'd3);
    ctrl_brake = 1'b0;
    cyc(1);
    chk2("p4_idle", state_o, 2'd0);
    chk1("p4_idle_a", pwm_a, 1'b0);
    chk1("p4_idle_b", pwm_b, 1'b0);
    cyc(1);
    chk2("p4_no_redead", state_o, 2'd1);
    chk1("p4_run_a", pwm_a, 1'b1);
    chk1("p4_run_b", pwm_b, 1'b0);

    // Period 1: outputs low, no tick
    ctrl_enable = 1'b0;
    cyc(1);
    chk2("p5_disable", state_o, 2'd0);
    chk1("p5_disable_a", pwm_a, 1'b0);
    cfg_period = 16'd1; cfg_duty = 16'd3; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    cyc(1);
    chk1("p5_pend_clr", update_pending, 1'b0);
    ctrl_enable = 1'b1;
    cyc(1);
    for (int k = 0; k < 12; k++) begin
      chk2("p5_p1_state", state_o, 2'd1);
      chk1("p5_p1_a", pwm_a, 1'b0);
      chk1("p5_p1_tick", period_tick, 1'b0);
      cyc(1);
    end

    // Duty 0 with period 10: never high, ticks continue
    cfg_period = 16'd10; cfg_duty = 16'd0; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    chk1("p5_d0_pend", update_pending, 1'b1);
    cyc(1);
    chk1("p5_d0_pend_clr", update_pending, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk1("p5_d0_a", pwm_a, 1'b0);
      chk1("p5_d0_tick", period_tick, k == 9);
      cyc(1);
    end

    // Duty 12 with period 10: constantly high
    cfg_duty = 16'd12; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    cyc(9);
    for (int k = 0; k < 10; k++) begin
      chk1("p5_d12_a", pwm_a, 1'b1);
      cyc(1);
    end

    // Strobe coincident with the wrap edge: stays pending for one period
    cyc(9);
    chk1("p6_wrap_tick", period_tick, 1'b1);
    cfg_duty = 16'd2; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk1("p6_hold_a", pwm_a, 1'b1);
      chk1("p6_hold_pend", update_pending, 1'b1);
      cyc(1);
    end
    chk1("p6_pend_clr", update_pending, 1'b0);
    chk1("p6_d2_cnt0", pwm_a, 1'b1);
    cyc(1);
    chk1("p6_d2_cnt1", pwm_a, 1'b1);
    cyc(1);
    chk1("p6_d2_cnt2", pwm_a, 1'b0);
    cyc(8);

    // Asynchronous reset mid-period with a staged update
    cfg_duty = 16'd4; cfg_update = 1'b1;
    cyc(1);
    cfg_update = 1'b0;
    chk1("p7_pre_a", pwm_a, 1'b1);
    chk1("p7_pre_pend", update_pending, 1'b1);
    ARESET = 1'b1;
    #2;
    chk1("p7_rst_a", pwm_a, 1'b0);
    chk1("p7_rst_b", pwm_b, 1'b0);
    chk1("p7_rst_tick", period_tick, 1'b0);
    chk1("p7_rst_pend", update_pending, 1'b0);
    chk2("p7_rst_state", state_o, 2'd0);
    ctrl_enable = 1'b0;
    @(negedge tb_ACLK);
    ARESET = 1'b0;
    cyc(2);
    chk2("p7_post_state", state_o, 2'd0);
    chk1("p7_post_pend", update_pending, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_core.md
Name: motor_pwm_core

Overview:
Downstream of the motor_driver AXI4-Lite register slave. Consumes the control/period/duty/direction register contents plus a write-update strobe. Generates shadow-buffered, glitch-free PWM for one H-bridge. Enforces dead time on every direction reversal and a live brake/enable override.

Parameters:
CNT_W, 16, width of period/duty counters
DEADTIME_CYCLES, 50, ACLK cycles both bridge legs held low on reversal (>=1)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset, asynchronous, active-high
ctrl_enable  in  1  live enable from control register bit 0
ctrl_brake  in  1  live brake from control register bit 1
cfg_dir  in  1  requested direction (0 fwd, 1 rev), staged
cfg_period  in  CNT_W  PWM period in ACLK cycles, staged
cfg_duty  in  CNT_W  high-time in ACLK cycles, staged
cfg_update  in  1  single-cycle strobe: capture cfg_* into staging
pwm_a  out  1  bridge leg A (PWM when dir=0)
pwm_b  out  1  bridge leg B (PWM when dir=1)
period_tick  out  1  one-cycle pulse at each counter wrap in RUN
update_pending  out  1  staged values not yet applied
state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 DEAD, 3 BRAKE

Behaviour:
- Reset: all outputs 0; counter 0; active/staged period, duty and dir 0; FSM IDLE.
- All outputs registered. Decisions from inputs sampled at edge N are visible after edge N, i.e. during cycle N+1.
- Staging: cfg_update captures cfg_dir/period/duty into staging and sets update_pending. A repeat strobe before apply overwrites staging (last write wins).
- Apply point: in IDLE, apply immediately. In RUN, apply at the wrap edge (cnt == act_period-1). Applying clears update_pending. If cfg_update coincides with an apply edge, the new strobe wins and pending stays 1.
- Counter (RUN): cnt runs 0..act_period-1, then wraps to 0. period_tick=1 on the wrap cycle.
- Degenerate period: act_period<2 means outputs low and cnt held 0, with no period_tick.
- PWM: active leg = (cnt < act_duty). act_duty >= act_period gives 100%; act_duty=0 gives 0%. The inactive leg is always 0 in RUN.
- FSM priority per edge: ctrl_brake > !ctrl_enable > normal.
  - Any state, brake=1 → BRAKE: pwm_a=pwm_b=1, cnt 0.
  - Any state except BRAKE, enable=0 → IDLE: outputs 0, cnt 0.
  - BRAKE, brake=0 → IDLE.
  - IDLE, enable=1 → apply pending, then RUN. If the applied dir differs from the last driven dir → DEAD instead.
  - RUN, apply with staged dir != act_dir → DEAD: both legs 0, dead counter loaded DEADTIME_CYCLES, act_dir updated.
  - DEAD: decrement each cycle. At 0 → RUN with cnt=0.
- No direction change ever drives both legs high outside BRAKE. No cycle ever has the new leg high within DEADTIME_CYCLES of the old leg low.
- Reset mid-operation: asynchronous clear to the reset values above; staging is lost.
- cfg_update during DEAD or BRAKE: staged only. It is applied on the next RUN wrap, or at the IDLE→RUN transition.

Decomposition:
- Shared package motor_pkg holds the state enum (IDLE/RUN/DEAD/BRAKE, 2-bit), control bit indices (ENABLE=0, BRAKE=1, DIR=2) and the default CNT_W.
- One sub-module, pwm_shadow_regs: staging + active registers, update_pending, apply logic. The FSM/counter stays in the top level.

Test Plan:
- Reset release, enable=1, period=10, duty=3, dir=0, update → pwm_a high 3 of every 10 cycles, pwm_b 0, period_tick every 10 cycles, update_pending cleared.
- In RUN, update duty=7 mid-period → old duty holds until wrap. The next period has 7 high cycles; update_pending is 1 until the wrap edge.
- In RUN, dir=1 update (DEADTIME_CYCLES=50) → at wrap both legs 0 for exactly 50 cycles and state_o=2, then pwm_b PWM starting at cnt=0, pwm_a stays 0.
- brake=1 during DEAD → next cycle pwm_a=pwm_b=1, state_o=3. Brake=0 → IDLE with outputs 0. Re-enable → DEAD not repeated if dir is unchanged.
- Period edge cases: period=1 → outputs low, no tick. duty=0 → 0%. duty=12 with period=10 → pwm_a constantly 1.
- ARESET asserted mid-period and cfg_update coincident with wrap → immediate zeroed outputs. On the coincident case, pending stays 1 and the new values apply at the next wrap.
